// File: rtl/buzz_arb_pkg.sv
// Shared definitions for the buzzer arbiter: state encoding, tone codes, counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package buzz_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEY    = 3'd1,
    ST_CHIME  = 3'd2,
    ST_ALARM  = 3'd3,
    ST_SNOOZE = 3'd4
  } state_e;

  localparam logic [1:0] TONE_NONE  = 2'b00;
  localparam logic [1:0] TONE_KEY   = 2'b01;
  localparam logic [1:0] TONE_CHIME = 2'b10;
  localparam logic [1:0] TONE_ALARM = 2'b11;

  localparam int TICK_W = 16;
  localparam int KEY_W  = 32;

  // Tone source driven while sitting in a given state.
  function automatic logic [1:0] tone_of(input state_e s);
    case (s)
      ST_KEY:   return TONE_KEY;
      ST_CHIME: return TONE_CHIME;
      ST_ALARM: return TONE_ALARM;
      default:  return TONE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/buzz_sec_timer.sv
// Counts 1 Hz ticks since the last clear and flags the terminal tick.
// Latency: o_done is combinational on the tick that reaches i_term.
// Backpressure: none; ticks outside i_tick are not counted.
module buzz_sec_timer
  import buzz_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_tick,
  input  logic [TICK_W-1:0] i_term,
  output logic              o_done
);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;

  // Clear wins over a coincident tick so a fresh state always starts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_tick) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Tick count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The owning state leaves on this tick, so the count never wraps.
  assign o_done = i_tick && (cnt_q == i_term - 16'd1);

endmodule

// File: rtl/buzz_arb.sv
// Buzzer arbiter: alarm > chime > key, with optional snooze (macro BUZZ_ARB_SNOOZE_EN).
// Latency: a request sampled at edge N shows on the registered outputs after edge N+1.
// Backpressure: none; one chime is buffered, key presses outside IDLE/KEY are dropped.
module buzz_arb
  import buzz_arb_pkg::*;
#(
  parameter int unsigned KEY_CYCLES    = 5000000,
  parameter int unsigned CHIME_SEC     = 2,
  parameter int unsigned ALARM_TIMEOUT = 60,
  parameter int unsigned SNOOZE_SEC    = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick_1hz,
  input  logic       i_alarm_req,
  input  logic       i_chime_req,
  input  logic       i_key_req,
  input  logic       i_stop,
  input  logic       i_snooze,
  output logic       o_buzz_en,
  output logic [1:0] o_tone_sel,
  output logic [2:0] o_state,
  output logic       o_snoozed
);

  localparam logic [KEY_W-1:0]  KEY_LAST   = KEY_CYCLES - 32'd1;
  localparam logic [TICK_W-1:0] CHIME_TC   = TICK_W'(CHIME_SEC);
  localparam logic [TICK_W-1:0] ALARM_TC   = TICK_W'(ALARM_TIMEOUT);
  localparam logic [TICK_W-1:0] SNOOZE_TC  = TICK_W'(SNOOZE_SEC);

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_cnt_q, key_cnt_d;
  logic              pend_q, pend_d;
  logic              alarm_q, alarm_d;
  logic              arm_q, arm_d;
  logic              buzz_q, buzz_d;
  logic [1:0]        tone_q, tone_d;
  logic [2:0]        st_out_q, st_out_d;

  logic              alarm_edge;
  logic              snooze_go;
  logic              tick_en;
  logic              tmr_clr;
  logic              tmr_done;
  logic [TICK_W-1:0] tmr_term;

`ifdef BUZZ_ARB_SNOOZE_EN
  assign snooze_go = i_snooze;
`else
  logic unused_snooze;
  assign snooze_go     = 1'b0;
  assign unused_snooze = i_snooze;
`endif

  // arm_q masks the first cycle after reset so a level left high is not seen as a new edge.
  assign alarm_edge = arm_q && i_alarm_req && !alarm_q;

  // Edge-detect history and post-reset arming.
  always_comb begin
    alarm_d = i_alarm_req;
    arm_d   = 1'b1;
  end

  // Only timed states consume ticks; the shared timer restarts on every state change.
  assign tick_en = i_tick_1hz &&
                   (state_q == ST_CHIME || state_q == ST_ALARM || state_q == ST_SNOOZE);
  assign tmr_clr = (state_d != state_q);

  // Terminal tick count for whichever timed state currently owns the timer.
  always_comb begin
    tmr_term = ALARM_TC;
    case (state_q)
      ST_CHIME:  tmr_term = CHIME_TC;
      ST_SNOOZE: tmr_term = SNOOZE_TC;
      default:   tmr_term = ALARM_TC;
    endcase
  end

  buzz_sec_timer u_sec_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (tmr_clr),
    .i_tick (tick_en),
    .i_term (tmr_term),
    .o_done (tmr_done)
  );

  // Next-state, key counter and chime-pending logic.
  always_comb begin
    state_d   = state_q;
    key_cnt_d = key_cnt_q;
    pend_d    = pend_q;
    case (state_q)
      ST_IDLE: begin
        // An alarm edge landing with stop is treated as already acknowledged.
        if (alarm_edge && !i_stop) begin
          state_d = ST_ALARM;
        end else if (pend_q || i_chime_req) begin
          state_d = ST_CHIME;
        end else if (i_key_req) begin
          state_d   = ST_KEY;
          key_cnt_d = '0;
        end
      end
      ST_KEY: begin
        if (i_chime_req) pend_d = 1'b1;
        if (alarm_edge) begin
          state_d   = ST_ALARM;
          key_cnt_d = '0;
        end else if (i_key_req) begin
          key_cnt_d = '0;
        end else if (key_cnt_q == KEY_LAST) begin
          state_d   = ST_IDLE;
          key_cnt_d = '0;
        end else begin
          key_cnt_d = key_cnt_q + 32'd1;
        end
      end
      ST_CHIME: begin
        // A preempted chime is finished, not re-queued.
        if (alarm_edge) begin
          state_d = ST_ALARM;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_ALARM: begin
        if (i_chime_req) pend_d = 1'b1;
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (snooze_go) begin
          state_d = ST_SNOOZE;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        if (i_chime_req) pend_d = 1'b1;
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          state_d = ST_ALARM;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        key_cnt_d = '0;
      end
    endcase
    if (state_d == ST_CHIME && state_q != ST_CHIME) pend_d = 1'b0;
  end

  // Outputs are a registered decode of the current state.
  always_comb begin
    buzz_d   = (state_q == ST_KEY) || (state_q == ST_CHIME) || (state_q == ST_ALARM);
    tone_d   = tone_of(state_q);
    st_out_d = state_q;
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      key_cnt_q <= '0;
      pend_q    <= 1'b0;
      alarm_q   <= 1'b0;
      arm_q     <= 1'b0;
      buzz_q    <= 1'b0;
      tone_q    <= TONE_NONE;
      st_out_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      key_cnt_q <= key_cnt_d;
      pend_q    <= pend_d;
      alarm_q   <= alarm_d;
      arm_q     <= arm_d;
      buzz_q    <= buzz_d;
      tone_q    <= tone_d;
      st_out_q  <= st_out_d;
    end
  end

`ifdef BUZZ_ARB_SNOOZE_EN
  logic snz_q, snz_d;

  // Snooze indicator decode.
  always_comb begin
    snz_d = (state_q == ST_SNOOZE);
  end

  // Snooze indicator register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snz_q <= 1'b0;
    end else begin
      snz_q <= snz_d;
    end
  end

  assign o_snoozed = snz_q;
`else
  assign o_snoozed = 1'b0;
`endif

  assign o_buzz_en  = buzz_q;
  assign o_tone_sel = tone_q;
  assign o_state    = st_out_q;

endmodule

// File: tb/tb_buzz_arb.sv
// Bench for buzz_arb: directed scenarios then random traffic against a countdown model.
// Latency: model outputs lag the model state by one edge, like the registered DUT outputs.
// Backpressure: n/a.
module tb_buzz_arb;

  localparam int KEY_CYCLES    = 8;
  localparam int CHIME_SEC     = 2;
  localparam int ALARM_TIMEOUT = 4;
  localparam int SNOOZE_SEC    = 3;

  localparam int M_IDLE   = 0;
  localparam int M_KEY    = 1;
  localparam int M_CHIME  = 2;
  localparam int M_ALARM  = 3;
  localparam int M_SNOOZE = 4;

`ifdef BUZZ_ARB_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_tick_1hz = 1'b0;
  logic       i_alarm_req = 1'b0;
  logic       i_chime_req = 1'b0;
  logic       i_key_req = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_snooze = 1'b0;
  logic       o_buzz_en;
  logic [1:0] o_tone_sel;
  logic [2:0] o_state;
  logic       o_snoozed;

  int checks = 0;
  int errors = 0;

  // Reference model: mode plus remaining-time countdowns.
  int   m_mode = M_IDLE;
  int   m_key_left = 0;
  int   m_ticks_left = 0;
  bit   m_pend = 1'b0;
  bit   m_prev = 1'b1;
  logic       e_buzz = 1'b0;
  logic [1:0] e_tone = 2'd0;
  logic [2:0] e_state = 3'd0;
  logic       e_snz = 1'b0;

  buzz_arb #(
    .KEY_CYCLES    (KEY_CYCLES),
    .CHIME_SEC     (CHIME_SEC),
    .ALARM_TIMEOUT (ALARM_TIMEOUT),
    .SNOOZE_SEC    (SNOOZE_SEC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tick_1hz  (i_tick_1hz),
    .i_alarm_req (i_alarm_req),
    .i_chime_req (i_chime_req),
    .i_key_req   (i_key_req),
    .i_stop      (i_stop),
    .i_snooze    (i_snooze),
    .o_buzz_en   (o_buzz_en),
    .o_tone_sel  (o_tone_sel),
    .o_state     (o_state),
    .o_snoozed   (o_snoozed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic enter_chime();
    m_mode = M_CHIME;
    m_pend = 1'b0;
    m_ticks_left = CHIME_SEC;
  endtask

  task automatic enter_alarm();
    m_mode = M_ALARM;
    m_ticks_left = ALARM_TIMEOUT;
  endtask

  // Advance the model by one clock edge using the inputs the DUT samples there.
  task automatic model_step();
    bit rise;
    if (!rst_n) begin
      m_mode = M_IDLE; m_pend = 1'b0; m_prev = 1'b1;
      e_buzz = 1'b0; e_tone = 2'd0; e_state = 3'd0; e_snz = 1'b0;
      return;
    end
    e_buzz  = (m_mode == M_KEY || m_mode == M_CHIME || m_mode == M_ALARM);
    e_tone  = (m_mode == M_SNOOZE) ? 2'd0 : 2'(m_mode);
    e_state = 3'(m_mode);
    e_snz   = (m_mode == M_SNOOZE);
    rise   = i_alarm_req && !m_prev;
    m_prev = i_alarm_req;
    case (m_mode)
      M_IDLE: begin
        if (rise && !i_stop) enter_alarm();
        else if (m_pend || i_chime_req) enter_chime();
        else if (i_key_req) begin m_mode = M_KEY; m_key_left = KEY_CYCLES; end
      end
      M_KEY: begin
        if (i_chime_req) m_pend = 1'b1;
        if (rise) enter_alarm();
        else if (i_key_req) m_key_left = KEY_CYCLES;
        else begin
          m_key_left--;
          if (m_key_left == 0) m_mode = M_IDLE;
        end
      end
      M_CHIME: begin
        if (rise) enter_alarm();
        else if (i_tick_1hz) begin
          m_ticks_left--;
          if (m_ticks_left == 0) m_mode = M_IDLE;
        end
      end
      M_ALARM: begin
        if (i_chime_req) m_pend = 1'b1;
        if (i_stop) m_mode = M_IDLE;
        else if (i_snooze && SNZ_EN) begin m_mode = M_SNOOZE; m_ticks_left = SNOOZE_SEC; end
        else if (i_tick_1hz) begin
          m_ticks_left--;
          if (m_ticks_left == 0) m_mode = M_IDLE;
        end
      end
      default: begin
        if (i_chime_req) m_pend = 1'b1;
        if (i_stop) m_mode = M_IDLE;
        else if (i_tick_1hz) begin
          m_ticks_left--;
          if (m_ticks_left == 0) enter_alarm();
        end
      end
    endcase
  endtask

  // One clock: model at the edge, compare all outputs just after it.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("buzz_en", 32'(o_buzz_en), 32'(e_buzz));
    chk("tone_sel", 32'(o_tone_sel), 32'(e_tone));
    chk("state", 32'(o_state), 32'(e_state));
    chk("snoozed", 32'(o_snoozed), 32'(e_snz));
  endtask

  task automatic do_tick();
    i_tick_1hz = 1'b1; step(); i_tick_1hz = 1'b0; step();
  endtask

  task automatic alarm_rise();
    i_alarm_req = 1'b1; step(); i_alarm_req = 1'b0; step(); step();
  endtask

  initial begin
    int n;
    int first;

    // Reset state
    rst_n = 1'b0;
    step(); step();
    chk("rst_buzz", 32'(o_buzz_en), 32'd0);
    chk("rst_tone", 32'(o_tone_sel), 32'd0);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_snz", 32'(o_snoozed), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // Key beep: starts one cycle after the pulse and lasts KEY_CYCLES cycles
    i_key_req = 1'b1; step(); i_key_req = 1'b0;
    chk("key_lag", 32'(o_buzz_en), 32'd0);
    n = 0; first = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (o_buzz_en && o_tone_sel == 2'b01) begin
        n++;
        if (first < 0) first = i;
      end
    end
    chk("key_len", 32'(n), 32'd8);
    chk("key_start", 32'(first), 32'd1);

    // Alarm edge preempts chime; held level never retriggers
    i_chime_req = 1'b1; step(); i_chime_req = 1'b0; step(); step();
    chk("chime_on", 32'(o_state), 32'd2);
    i_alarm_req = 1'b1; step(); step();
    chk("preempt_state", 32'(o_state), 32'd3);
    chk("preempt_tone", 32'(o_tone_sel), 32'd3);
    repeat (ALARM_TIMEOUT) do_tick();
    chk("alarm_to_state", 32'(o_state), 32'd0);
    chk("alarm_to_buzz", 32'(o_buzz_en), 32'd0);
    repeat (6) step();
    chk("no_retrig", 32'(o_state), 32'd0);
    i_alarm_req = 1'b0; step();

    // Snooze after two ticks, then back to alarm, then timeout
    alarm_rise();
    do_tick(); do_tick();
    i_snooze = 1'b1; step(); i_snooze = 1'b0; step(); step();
`ifdef BUZZ_ARB_SNOOZE_EN
    chk("snz_flag", 32'(o_snoozed), 32'd1);
    chk("snz_buzz", 32'(o_buzz_en), 32'd0);
    chk("snz_state", 32'(o_state), 32'd4);
`else
    chk("nosnz_flag", 32'(o_snoozed), 32'd0);
    chk("nosnz_state", 32'(o_state), 32'd3);
`endif
    repeat (SNOOZE_SEC) do_tick();
`ifdef BUZZ_ARB_SNOOZE_EN
    chk("resnz_alarm", 32'(o_state), 32'd3);
`else
    chk("nosnz_done", 32'(o_state), 32'd0);
`endif
    repeat (ALARM_TIMEOUT) do_tick();
    chk("snz_end", 32'(o_state), 32'd0);

    // Chimes buffered during alarm replay once after stop
    alarm_rise();
    i_chime_req = 1'b1; step(); i_chime_req = 1'b0; step();
    i_chime_req = 1'b1; step(); i_chime_req = 1'b0; step();
    i_stop = 1'b1; step(); i_stop = 1'b0;
    step(); step();
    chk("pend_chime", 32'(o_state), 32'd2);
    repeat (CHIME_SEC) do_tick();
    chk("pend_done", 32'(o_state), 32'd0);
    repeat (3) step();
    chk("pend_once", 32'(o_state), 32'd0);

    // Stop beats snooze in the same cycle
    alarm_rise();
    i_stop = 1'b1; i_snooze = 1'b1; step(); i_stop = 1'b0; i_snooze = 1'b0; step();
    chk("stop_wins_state", 32'(o_state), 32'd0);
    chk("stop_wins_snz", 32'(o_snoozed), 32'd0);

    // Reset mid-alarm with the request still high
    i_alarm_req = 1'b1; step(); step(); step();
    chk("pre_rst_alarm", 32'(o_state), 32'd3);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mid_rst_state", 32'(o_state), 32'd0);
    chk("mid_rst_buzz", 32'(o_buzz_en), 32'd0);
    chk("mid_rst_tone", 32'(o_tone_sel), 32'd0);
    repeat (4) step();
    chk("post_rst_quiet", 32'(o_state), 32'd0);
    i_alarm_req = 1'b0; step();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      i_tick_1hz  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 30) == 0) i_alarm_req = ~i_alarm_req;
      i_chime_req = ($urandom_range(0, 40) == 0);
      i_key_req   = ($urandom_range(0, 15) == 0);
      i_stop      = ($urandom_range(0, 50) == 0);
      i_snooze    = ($urandom_range(0, 25) == 0);
      rst_n       = ($urandom_range(0, 400) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzz_arb.md
BUZZ_ARB -- requirements
Module: buzz_arb

Interface
REQ-001 Parameter KEY_CYCLES, default 5000000, key-beep length in clk cycles (100 ms at 50 MHz); legal range 1..2^32-1.
REQ-002 Parameter CHIME_SEC, default 2, chime length in 1 Hz ticks; legal range 1..65535.
REQ-003 Parameter ALARM_TIMEOUT, default 60, alarm auto-off in ticks; legal range 1..65535.
REQ-004 Parameter SNOOZE_SEC, default 300, snooze length in ticks; legal range 1..65535.
REQ-005 Port clk, input, 1, system clock, 50 MHz.
REQ-006 Port rst_n, input, 1, reset; active-low, synchronous to clk.
REQ-007 Port i_tick_1hz, input, 1, one-cycle strobe, once per second.
REQ-008 Port i_alarm_req, input, 1, level, high while alarm time matches.
REQ-009 Port i_chime_req, input, 1, one-cycle hourly-chime pulse.
REQ-010 Port i_key_req, input, 1, one-cycle key-press beep pulse.
REQ-011 Port i_stop, input, 1, one-cycle debounced stop pulse.
REQ-012 Port i_snooze, input, 1, one-cycle debounced snooze pulse.
REQ-013 Port o_buzz_en, output, 1, buzzer enable for buzz.
REQ-014 Port o_tone_sel, output, 2, tone source: 00 none, 01 key, 10 chime, 11 alarm.
REQ-015 Port o_state, output, 3, current FSM state.
REQ-016 Port o_snoozed, output, 1, high in SNOOZE.

Function
REQ-017 States: IDLE=0, KEY=1, CHIME=2, ALARM=3, SNOOZE=4.
- All outputs are registered.
- A request sampled at edge N is reflected on the outputs after edge N+1.
REQ-018 Alarm trigger is the rising edge of i_alarm_req (registered compare).
- A held level never retriggers.
REQ-019 Priority is ALARM > CHIME > KEY.
- An alarm edge preempts KEY or CHIME on the next edge.
- A preempted KEY beep is discarded.
REQ-020 IDLE: alarm edge -> ALARM; else pending chime or i_chime_req -> CHIME; else i_key_req -> KEY.
REQ-021 KEY: exits to IDLE after exactly KEY_CYCLES cycles in state.
- i_key_req while in KEY restarts the count.
REQ-022 CHIME: exits to IDLE on the CHIME_SEC-th i_tick_1hz after entry.
REQ-023 Chime pending flag (one-deep buffer):
- Set by i_chime_req arriving in KEY, ALARM or SNOOZE.
- Repeated pulses merge into the single flag.
- Cleared on entry to CHIME.
REQ-024 ALARM:
- Tick counter cleared on entry.
- Exits to IDLE on the ALARM_TIMEOUT-th tick.
- i_stop -> IDLE.
- i_snooze -> SNOOZE.
REQ-025 SNOOZE:
- Exits to ALARM on the SNOOZE_SEC-th tick, with the ALARM timeout counter restarted.
- i_stop -> IDLE.
- i_snooze ignored.
- Alarm edge ignored.
REQ-026 Simultaneous-event resolution:
- i_stop beats i_snooze and beats a terminal tick in the same cycle.
- An alarm edge coincident with i_stop in IDLE is discarded.
- i_key_req outside IDLE/KEY is dropped.
REQ-027 Output values per state:
- o_buzz_en = 1 in KEY, CHIME and ALARM; 0 in IDLE and SNOOZE.
- o_tone_sel follows the state per REQ-014, and is 00 in IDLE and SNOOZE.
REQ-028 Tick counters are 16 bit and the key counter is 32 bit; counters never wrap inside a state.

Reset
REQ-029 While rst_n is 0 at a clk edge, the block returns to its reset condition:
- state IDLE;
- all counters 0;
- pending flag 0;
- alarm edge register 0;
- o_buzz_en=0, o_tone_sel=00, o_state=0, o_snoozed=0.
REQ-030 Reset mid-operation (any state) takes effect at that edge.
- An i_alarm_req still high after reset does not trigger.

Configuration
REQ-031 Macro BUZZ_ARB_SNOOZE_EN.
- Defined: SNOOZE state and i_snooze behave as above.
- Undefined: SNOOZE is never entered, i_snooze is ignored, and o_snoozed is tied 0.

Structure
REQ-032 Package buzz_arb_pkg holds:
- the state encoding;
- the o_tone_sel codes;
- the tick counter width constant.
REQ-033 One sub-module, buzz_sec_timer: clear input, tick-enable input, terminal-count input, done output.
- Instantiated once for CHIME/ALARM/SNOOZE (cleared on every state entry).
- The key counter stays inline.

Verification (bench parameters KEY_CYCLES=8, CHIME_SEC=2, ALARM_TIMEOUT=4, SNOOZE_SEC=3)
REQ-034 Key pulse in IDLE -> o_tone_sel=01 and o_buzz_en=1 for exactly 8 cycles starting 1 cycle later, then IDLE.
REQ-035 Alarm edge during CHIME:
- ALARM on the next edge;
- chime not resumed;
- after 4 ticks -> IDLE with o_buzz_en=0;
- i_alarm_req held high causes no retrigger.
REQ-036 Alarm sequence with i_snooze after 2 ticks:
- SNOOZE with o_snoozed=1 and o_buzz_en=0;
- after 3 ticks -> ALARM again;
- 4 more ticks -> IDLE.
REQ-037 Chime pulses (x2) during ALARM, then i_stop -> IDLE, then one CHIME of 2 ticks, then IDLE.
REQ-038 i_stop and i_snooze in the same cycle in ALARM -> IDLE.
REQ-039 rst_n low for one edge mid-ALARM -> all outputs reset next cycle.
REQ-040 Build with BUZZ_ARB_SNOOZE_EN undefined: i_snooze in ALARM has no effect and o_snoozed stays 0.
